udma_filter_au_sched: RTL and testbench
=======================================

Name: udma_filter_au_sched

Overview:
Frame sequencer in front of the filter arithmetic unit.
- Gates the operand-A stream into the AU and generates the AU's start, start-of-frame and end-of-frame markers from a programmed frame length and frame count.
- Counts AU results and signals completion once every expected result has left the AU.
- Sits between the uDMA RX channel and the AU's operand-A port, alongside the register file that programs it.

Parameters:
DATA_WIDTH, 32, width of the operand-A data path passed through to the AU.
CNT_WIDTH, 16, width of the frame-length and frame-count configuration fields and counters.

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-high reset
cfg_frame_len_i  in  CNT_WIDTH  samples per frame
cfg_frame_num_i  in  CNT_WIDTH  frames per job
cfg_acc_mode_i  in  1  1 = one AU result per frame (accumulate modes); 0 = one result per sample
cmd_start_i  in  1  job start pulse
cmd_stop_i  in  1  job abort pulse
in_data_i  in  DATA_WIDTH  upstream operand-A data
in_valid_i  in  1  upstream valid
in_ready_o  out  1  upstream ready
au_start_o  out  1  to AU cmd_start_i
au_opa_data_o  out  DATA_WIDTH  to AU operanda_data_i
au_opa_valid_o  out  1  to AU operanda_valid_i
au_opa_sof_o  out  1  to AU operanda_sof_i
au_opa_eof_o  out  1  to AU operanda_eof_i
au_opa_ready_i  in  1  from AU operanda_ready_o
au_out_valid_i  in  1  AU output_valid_o (observed)
au_out_ready_i  in  1  downstream ready toward AU (observed)
busy_o  out  1  job in progress
done_o  out  1  one-cycle pulse at normal completion
abort_o  out  1  one-cycle pulse at abort
frame_cnt_o  out  CNT_WIDTH  frames fully issued
sample_cnt_o  out  CNT_WIDTH  sample index within the current frame

Behaviour:
- Reset: state IDLE; all counters 0; busy_o, done_o, abort_o, au_start_o = 0.
- States:
  - IDLE: waiting for a job.
  - RUN: issuing samples.
  - DRAIN: all samples issued, waiting for the remaining results.
  - DONE: one cycle, then back to IDLE.
- IDLE, cmd_start_i = 1:
  - Latch len, num and acc_mode.
  - Pulse au_start_o for 1 cycle.
  - Clear counters; move to RUN.
  - Expected result count = acc_mode ? num : len*num, held in a 2*CNT_WIDTH register.
- cfg_frame_len_i = 0 or cfg_frame_num_i = 0 at start: au_start_o still pulses, go straight to DONE, done_o pulses on the next cycle.
- Pass-through, combinational:
  - au_opa_valid_o = in_valid_i & RUN
  - in_ready_o = au_opa_ready_i & RUN
  - au_opa_data_o = in_data_i
- Markers, combinational:
  - au_opa_sof_o = (sample_cnt == 0)
  - au_opa_eof_o = (sample_cnt == len-1)
  - Both are 1 when len = 1.
- Accepted sample = au_opa_valid_o & au_opa_ready_i. On each accepted sample, sample_cnt increments.
- On acceptance at len-1: sample_cnt wraps to 0 and frame_cnt increments.
- When frame_cnt reaches num: move RUN -> DRAIN.
- Result counter increments when au_out_valid_i & au_out_ready_i, in RUN or DRAIN.
- DRAIN -> DONE when result count equals expected. This includes the cycle in which the last result handshake occurs, so DONE is entered on the following edge.
- DONE: done_o = 1 for exactly 1 cycle; busy_o = 0 from DONE on.
- busy_o = 1 in RUN and DRAIN.
- cmd_start_i while busy: ignored.
- cmd_stop_i in RUN or DRAIN (higher priority than any same-cycle transition):
  - Pulse au_start_o to flush the AU pipeline.
  - Pulse abort_o; go to IDLE; no done_o.
- cmd_stop_i in IDLE: ignored.
- Latched configuration is stable for the whole job; later cfg changes take effect only at the next start.
- Results seen in IDLE are not counted.
- Result count saturates at the expected value.

Decomposition:
- Package udma_filter_pkg holds the state enum (IDLE, RUN, DRAIN, DONE) and the AU mode constants shared with the AU and the register file.
- One sub-module is natural: udma_filter_frame_cnt, a parameterised wrap counter producing first/last flags, instanced for the sample and frame counters.

Test Plan:
1. len=4, num=2, acc=0, upstream always valid, AU always ready:
   - au_start_o pulses once.
   - sof at samples 0 and 4, eof at samples 3 and 7.
   - After 8 result handshakes, done_o pulses once; frame_cnt_o=2.
2. len=3, num=2, acc=1:
   - 6 samples accepted; DRAIN entered after the 6th.
   - done_o fires only after the 2nd result handshake; extra results are not counted.
3. len=1, num=3, acc=0:
   - sof and eof high on every sample; done_o after 3 results.
4. Random gaps on in_valid_i and au_opa_ready_i, len=5, num=4:
   - Exactly 20 samples pass; sof/eof on indices 0/4 mod 5.
   - in_ready_o never high outside RUN.
5. cmd_stop_i mid-frame (len=8, num=2, stop after 5 samples):
   - au_start_o and abort_o pulse, busy_o drops, no done_o.
   - A following start runs a clean job.
6. Zero len or zero num at start:
   - au_start_o pulses, done_o next cycle, no samples accepted.
   - A cmd_start_i while busy is ignored and counters are unaffected.

Source files
------------

// File: rtl/udma_filter_pkg.sv
// Shared types for the filter datapath: sequencer states and AU operating modes.
package udma_filter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_e;

    localparam int AU_MODE_WIDTH = 3;

    // Accumulate modes yield one AU result per frame; the others yield one per sample.
    typedef enum logic [AU_MODE_WIDTH-1:0] {
        AU_MODE_ADD   = 3'd0,
        AU_MODE_MUL   = 3'd1,
        AU_MODE_SHIFT = 3'd2,
        AU_MODE_MAC   = 3'd3,
        AU_MODE_ACC   = 3'd4
    } au_mode_e;

endpackage

// File: rtl/udma_filter_frame_cnt.sv
// Counter with first/last flags; optionally wraps to zero after last_val_i.
// Latency: flags are combinational from the registered count.
// Backpressure: none, advances only on inc_i.
module udma_filter_frame_cnt #(
    parameter int WIDTH = 16,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [WIDTH-1:0] last_val_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             first_o,
    output logic             last_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i) begin
            if (WRAP && last_o) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + ONE;
            end
        end
    end

    assign cnt_o   = cnt_q;
    assign first_o = (cnt_q == '0);
    assign last_o  = (cnt_q == last_val_i);

endmodule

// File: rtl/udma_filter_au_sched.sv
// Frame sequencer gating operand A into the AU and tracking results to job completion.
// Latency: data/valid/ready are combinational pass-through; start/abort pulse in the command cycle.
// Backpressure: upstream ready follows AU ready while running, otherwise held low.
module udma_filter_au_sched
    import udma_filter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [CNT_WIDTH-1:0]  cfg_frame_len_i,
    input  logic [CNT_WIDTH-1:0]  cfg_frame_num_i,
    input  logic                  cfg_acc_mode_i,
    input  logic                  cmd_start_i,
    input  logic                  cmd_stop_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic                  au_start_o,
    output logic [DATA_WIDTH-1:0] au_opa_data_o,
    output logic                  au_opa_valid_o,
    output logic                  au_opa_sof_o,
    output logic                  au_opa_eof_o,
    input  logic                  au_opa_ready_i,
    input  logic                  au_out_valid_i,
    input  logic                  au_out_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  abort_o,
    output logic [CNT_WIDTH-1:0]  frame_cnt_o,
    output logic [CNT_WIDTH-1:0]  sample_cnt_o
);

    localparam int               RW  = 2 * CNT_WIDTH;
    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    sched_state_e         state_q, state_d;
    logic [CNT_WIDTH-1:0] len_q, num_q;
    logic [RW-1:0]        exp_q, exp_d, res_q, res_d;
    logic [RW-1:0]        len_w, num_w;
    logic                 run, start_job, accept;
    logic                 smp_first, smp_last, frm_last, frm_inc, frm_first_unused;
    logic                 res_hs;

    assign run       = (state_q == ST_RUN);
    assign start_job = (state_q == ST_IDLE) && cmd_start_i;
    assign accept    = au_opa_valid_o && au_opa_ready_i;
    assign frm_inc   = accept && smp_last;

    assign au_opa_valid_o = in_valid_i && run;
    assign in_ready_o     = au_opa_ready_i && run;
    assign au_opa_data_o  = in_data_i;
    assign au_opa_sof_o   = smp_first;
    assign au_opa_eof_o   = smp_last;

    udma_filter_frame_cnt #(.WIDTH(CNT_WIDTH), .WRAP(1'b1)) u_sample_cnt (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clr_i      (start_job),
        .inc_i      (accept),
        .last_val_i (len_q - ONE),
        .cnt_o      (sample_cnt_o),
        .first_o    (smp_first),
        .last_o     (smp_last)
    );

    // Frame count must be allowed to reach num, so it does not wrap.
    udma_filter_frame_cnt #(.WIDTH(CNT_WIDTH), .WRAP(1'b0)) u_frame_cnt (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clr_i      (start_job),
        .inc_i      (frm_inc),
        .last_val_i (num_q - ONE),
        .cnt_o      (frame_cnt_o),
        .first_o    (frm_first_unused),
        .last_o     (frm_last)
    );

    assign len_w = {{CNT_WIDTH{1'b0}}, cfg_frame_len_i};
    assign num_w = {{CNT_WIDTH{1'b0}}, cfg_frame_num_i};
    assign exp_d = cfg_acc_mode_i ? num_w : (len_w * num_w);

    // Results beyond the expected count are dropped so the count saturates.
    assign res_hs = au_out_valid_i && au_out_ready_i && busy_o && (res_q != exp_q);
    assign res_d  = res_q + {{(RW-1){1'b0}}, res_hs};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            num_q   <= '0;
            exp_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            if (start_job) begin
                len_q <= cfg_frame_len_i;
                num_q <= cfg_frame_num_i;
                exp_q <= exp_d;
                res_q <= '0;
            end else begin
                res_q <= res_d;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        au_start_o = 1'b0;
        abort_o    = 1'b0;
        done_o     = 1'b0;
        busy_o     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_start_i) begin
                    au_start_o = 1'b1;
                    if ((cfg_frame_len_i == '0) || (cfg_frame_num_i == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                busy_o = 1'b1;
                if (cmd_stop_i) begin
                    au_start_o = 1'b1;
                    abort_o    = 1'b1;
                    state_d    = ST_IDLE;
                end else if (frm_inc && frm_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy_o = 1'b1;
                if (cmd_stop_i) begin
                    au_start_o = 1'b1;
                    abort_o    = 1'b1;
                    state_d    = ST_IDLE;
                end else if (res_d == exp_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_udma_filter_au_sched.sv
// Directed bench for the AU frame sequencer with a negedge marker/pulse monitor.
module tb_udma_filter_au_sched;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [CW-1:0] cfg_frame_len_i, cfg_frame_num_i;
    logic          cfg_acc_mode_i, cmd_start_i, cmd_stop_i;
    logic [DW-1:0] in_data_i;
    logic          in_valid_i, in_ready_o;
    logic          au_start_o;
    logic [DW-1:0] au_opa_data_o;
    logic          au_opa_valid_o, au_opa_sof_o, au_opa_eof_o, au_opa_ready_i;
    logic          au_out_valid_i, au_out_ready_i;
    logic          busy_o, done_o, abort_o;
    logic [CW-1:0] frame_cnt_o, sample_cnt_o;

    udma_filter_au_sched #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .cfg_frame_len_i(cfg_frame_len_i), .cfg_frame_num_i(cfg_frame_num_i),
        .cfg_acc_mode_i(cfg_acc_mode_i), .cmd_start_i(cmd_start_i), .cmd_stop_i(cmd_stop_i),
        .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .au_start_o(au_start_o), .au_opa_data_o(au_opa_data_o), .au_opa_valid_o(au_opa_valid_o),
        .au_opa_sof_o(au_opa_sof_o), .au_opa_eof_o(au_opa_eof_o), .au_opa_ready_i(au_opa_ready_i),
        .au_out_valid_i(au_out_valid_i), .au_out_ready_i(au_out_ready_i),
        .busy_o(busy_o), .done_o(done_o), .abort_o(abort_o),
        .frame_cnt_o(frame_cnt_o), .sample_cnt_o(sample_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_bad = 0;

    // Monitor-owned tallies; the main sequence only reads them.
    int n_start = 0, n_done = 0, n_abort = 0, n_acc = 0, mark_bad = 0, viol = 0;
    int m_len = 1, m_idx = 0;

    always @(negedge clk_i) begin
        if (au_start_o && !busy_o) begin
            m_len = int'(cfg_frame_len_i);
            m_idx = 0;
        end
        if (au_start_o) n_start++;
        if (done_o)     n_done++;
        if (abort_o)    n_abort++;
        if ((in_ready_o || au_opa_valid_o) && !busy_o) viol++;
        if (au_opa_valid_o && au_opa_ready_i) begin
            n_acc++;
            if (m_len == 0) mark_bad++;
            else begin
                if (au_opa_sof_o !== ((m_idx % m_len) == 0))         mark_bad++;
                if (au_opa_eof_o !== ((m_idx % m_len) == m_len - 1)) mark_bad++;
                if (au_opa_data_o !== in_data_i)                     mark_bad++;
            end
            m_idx++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic cfg(input int len, input int num, input logic acc);
        cfg_frame_len_i = CW'(len);
        cfg_frame_num_i = CW'(num);
        cfg_acc_mode_i  = acc;
    endtask

    int s_start, s_done, s_abort, s_acc;
    bit got_done;

    initial begin
        reset_i = 1'b1;
        cfg(0, 0, 1'b0);
        cmd_start_i = 0; cmd_stop_i = 0;
        in_data_i = 32'hA5A5_0000; in_valid_i = 0;
        au_opa_ready_i = 1; au_out_valid_i = 0; au_out_ready_i = 1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_abort", 64'(abort_o), 64'd0);
        chk("rst_au_start", 64'(au_start_o), 64'd0);
        chk("rst_frame", 64'(frame_cnt_o), 64'd0);
        chk("rst_sample", 64'(sample_cnt_o), 64'd0);
        chk("rst_in_ready", 64'(in_ready_o), 64'd0);
        reset_i = 1'b0;
        step();

        // ---- 1: len=4 num=2 per-sample results
        s_start = n_start; s_done = n_done; s_acc = n_acc;
        cfg(4, 2, 1'b0);
        in_valid_i = 1; cmd_start_i = 1;
        settle();
        chk("t1_au_start", 64'(au_start_o), 64'd1);
        chk("t1_idle_valid", 64'(au_opa_valid_o), 64'd0);
        step();
        cmd_start_i = 0;
        for (int i = 0; i < 8; i++) begin
            in_data_i = 32'hA5A5_0000 + 32'(i);
            step();
        end
        chk("t1_frame", 64'(frame_cnt_o), 64'd2);
        chk("t1_drain_busy", 64'(busy_o), 64'd1);
        chk("t1_drain_in_ready", 64'(in_ready_o), 64'd0);
        au_out_valid_i = 1;
        repeat (7) step();
        chk("t1_no_early_done", 64'(done_o), 64'd0);
        step();
        au_out_valid_i = 0;
        chk("t1_done", 64'(done_o), 64'd1);
        chk("t1_busy_in_done", 64'(busy_o), 64'd0);
        step();
        chk("t1_done_one_cycle", 64'(done_o), 64'd0);
        chk("t1_start_pulses", 64'(n_start - s_start), 64'd1);
        chk("t1_done_pulses", 64'(n_done - s_done), 64'd1);
        chk("t1_accepted", 64'(n_acc - s_acc), 64'd8);

        // ---- 2: len=3 num=2 accumulate mode, two results
        s_done = n_done; s_acc = n_acc;
        cfg(3, 2, 1'b1);
        cmd_start_i = 1;
        step();
        cmd_start_i = 0;
        repeat (6) step();
        chk("t2_accepted", 64'(n_acc - s_acc), 64'd6);
        chk("t2_drain_in_ready", 64'(in_ready_o), 64'd0);
        chk("t2_frame", 64'(frame_cnt_o), 64'd2);
        au_out_valid_i = 1;
        step();
        chk("t2_done_after_1", 64'(done_o), 64'd0);
        chk("t2_busy_after_1", 64'(busy_o), 64'd1);
        step();
        chk("t2_done_after_2", 64'(done_o), 64'd1);
        repeat (2) step();
        au_out_valid_i = 0;
        chk("t2_done_pulses", 64'(n_done - s_done), 64'd1);

        // ---- 3: len=1 num=3, results arrive during RUN and extras in DRAIN are dropped
        s_done = n_done; s_acc = n_acc;
        cfg(1, 3, 1'b0);
        cmd_start_i = 1;
        step();
        cmd_start_i = 0;
        au_out_valid_i = 1;
        repeat (3) step();
        chk("t3_frame", 64'(frame_cnt_o), 64'd3);
        chk("t3_not_done_yet", 64'(done_o), 64'd0);
        step();
        au_out_valid_i = 0;
        chk("t3_done", 64'(done_o), 64'd1);
        chk("t3_accepted", 64'(n_acc - s_acc), 64'd3);
        step();

        // ---- 4: len=5 num=4 with random gaps
        s_done = n_done; s_acc = n_acc;
        cfg(5, 4, 1'b0);
        cmd_start_i = 1;
        step();
        cmd_start_i = 0;
        for (int c = 0; c < 600 && frame_cnt_o != 16'd4; c++) begin
            in_valid_i     = 1'($urandom_range(0, 1));
            au_opa_ready_i = 1'($urandom_range(0, 1));
            in_data_i      = $urandom;
            step();
        end
        in_valid_i = 1; au_opa_ready_i = 1;
        settle();
        chk("t4_frame", 64'(frame_cnt_o), 64'd4);
        chk("t4_accepted", 64'(n_acc - s_acc), 64'd20);
        chk("t4_drain_in_ready", 64'(in_ready_o), 64'd0);
        got_done = 0;
        for (int c = 0; c < 300 && !got_done; c++) begin
            au_out_valid_i = 1'($urandom_range(0, 1));
            step();
            if (done_o) got_done = 1;
        end
        au_out_valid_i = 0;
        chk("t4_done_seen", 64'(got_done), 64'd1);
        chk("t4_accepted_total", 64'(n_acc - s_acc), 64'd20);
        step();

        // ---- 5: abort mid-frame, then a clean job
        s_done = n_done; s_abort = n_abort; s_start = n_start;
        cfg(8, 2, 1'b0);
        cmd_start_i = 1;
        step();
        cmd_start_i = 0;
        repeat (5) step();
        chk("t5_sample_mid", 64'(sample_cnt_o), 64'd5);
        in_valid_i = 0; cmd_stop_i = 1;
        settle();
        chk("t5_stop_au_start", 64'(au_start_o), 64'd1);
        chk("t5_abort", 64'(abort_o), 64'd1);
        step();
        cmd_stop_i = 0;
        chk("t5_busy_drop", 64'(busy_o), 64'd0);
        chk("t5_abort_one_cycle", 64'(abort_o), 64'd0);
        step();
        chk("t5_no_done", 64'(n_done - s_done), 64'd0);
        cfg(2, 1, 1'b0);
        in_valid_i = 1; cmd_start_i = 1;
        step();
        cmd_start_i = 0;
        chk("t5_restart_sample", 64'(sample_cnt_o), 64'd0);
        chk("t5_restart_busy", 64'(busy_o), 64'd1);
        repeat (2) step();
        chk("t5_restart_frame", 64'(frame_cnt_o), 64'd1);
        au_out_valid_i = 1;
        repeat (2) step();
        au_out_valid_i = 0;
        chk("t5_restart_done", 64'(done_o), 64'd1);
        step();
        chk("t5_abort_pulses", 64'(n_abort - s_abort), 64'd1);
        chk("t5_start_pulses", 64'(n_start - s_start), 64'd3);

        // ---- 6: zero length / zero count, stop in IDLE, start while busy
        s_acc = n_acc; s_abort = n_abort;
        cfg(0, 3, 1'b0);
        cmd_start_i = 1;
        settle();
        chk("t6_len0_au_start", 64'(au_start_o), 64'd1);
        step();
        cmd_start_i = 0;
        chk("t6_len0_done", 64'(done_o), 64'd1);
        chk("t6_len0_busy", 64'(busy_o), 64'd0);
        step();
        cfg(4, 0, 1'b0);
        cmd_start_i = 1;
        step();
        cmd_start_i = 0;
        chk("t6_num0_done", 64'(done_o), 64'd1);
        step();
        cmd_stop_i = 1;
        settle();
        chk("t6_idle_stop_abort", 64'(abort_o), 64'd0);
        chk("t6_idle_stop_au_start", 64'(au_start_o), 64'd0);
        step();
        cmd_stop_i = 0;
        chk("t6_zero_jobs_no_accept", 64'(n_acc - s_acc), 64'd0);
        cfg(4, 1, 1'b0);
        cmd_start_i = 1;
        step();
        cmd_start_i = 0;
        repeat (2) step();
        cfg(2, 5, 1'b1);
        cmd_start_i = 1;
        settle();
        chk("t6_busy_start_ignored", 64'(au_start_o), 64'd0);
        step();
        cmd_start_i = 0;
        chk("t6_busy_sample", 64'(sample_cnt_o), 64'd3);
        chk("t6_busy_frame", 64'(frame_cnt_o), 64'd0);
        step();
        chk("t6_len_kept_frame", 64'(frame_cnt_o), 64'd1);
        chk("t6_len_kept_in_ready", 64'(in_ready_o), 64'd0);
        au_out_valid_i = 1;
        repeat (4) step();
        au_out_valid_i = 0;
        chk("t6_busy_job_done", 64'(done_o), 64'd1);
        step();
        chk("t6_abort_none", 64'(n_abort - s_abort), 64'd0);

        chk("markers_all_jobs", 64'(mark_bad), 64'd0);
        chk("ready_outside_run", 64'(viol), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
